// File: rtl/vector_field_sequencer.sv
// Walks the velocity grid once per frame and hands each non-negligible cell's
// centre, unit direction and clamped magnitude to draw_block.
//
// state     | meaning
// IDLE      | waiting for frame_start
// RD        | vel_addr presented for the current cell
// CAP       | RAM data valid; capture |u|, |v| and signs
// MAG       | alpha-max-beta-min magnitude; skip negligible cells
// DIV       | 32-cycle restoring divide of |u|,|v| by the magnitude
// ISSUE     | start pulse with registered cell outputs
// DRAW_WAIT | fixed window reserved for draw_block
// NEXT      | advance col/row, or finish the frame
// DONE      | frame_done pulse, busy drops
module vector_field_sequencer #(
  parameter int          GRID_W      = 8,
  parameter int          GRID_H      = 6,
  parameter int          CELL_SIZE   = 40,
  parameter int          VEL_ADDRW   = $clog2(GRID_W*GRID_H),
  parameter int          DRAW_CYCLES = 256,
  parameter logic [31:0] MIN_MAG     = 32'h0000_0100,
  parameter logic [31:0] MAX_MAG     = 32'h0014_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_start,
  output logic                 busy,
  output logic                 frame_done,
  output logic [VEL_ADDRW-1:0] vel_addr,
  input  logic [31:0]          vel_u,
  input  logic [31:0]          vel_v,
  output logic                 start,
  output logic [31:0]          block_x,
  output logic [31:0]          block_y,
  output logic [31:0]          xn,
  output logic [31:0]          yn,
  output logic [31:0]          mag
);

  localparam int CW  = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int RW  = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam int WCW = $clog2(DRAW_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RD, S_CAP, S_MAG, S_DIV, S_ISSUE, S_DRAW_WAIT, S_NEXT, S_DONE
  } state_t;

  state_t         state;
  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [31:0]    au;
  logic [31:0]    av;
  logic           su;
  logic           sv;
  logic [31:0]    m_q;
  logic [31:0]    rem_x;
  logic [31:0]    rem_y;
  logic [31:0]    dvd_x;
  logic [31:0]    dvd_y;
  logic [30:0]    q_x;
  logic [30:0]    q_y;
  logic [4:0]     div_cnt;
  logic [WCW-1:0] wait_cnt;

  logic [31:0] mx;
  logic [31:0] mn;
  logic [33:0] m_sum;
  logic [31:0] m_sat;
  logic [32:0] trial_x;
  logic [32:0] trial_y;
  logic [31:0] diff_x;
  logic [31:0] diff_y;
  logic        ge_x;
  logic        ge_y;
  logic [31:0] q_x_nx;
  logic [31:0] q_y_nx;
  logic [31:0] qs_x;
  logic [31:0] qs_y;
  logic [31:0] cx;
  logic [31:0] cy;

  function automatic logic [31:0] abs_sat(input logic [31:0] x);
    if (x == 32'h8000_0000) return 32'h7FFF_FFFF;
    return x[31] ? (~x + 32'd1) : x;
  endfunction

  assign mx    = (au >= av) ? au : av;
  assign mn    = (au >= av) ? av : au;
  assign m_sum = {2'b00, mx} + 34'(mn >> 2) + 34'(mn >> 3);
  assign m_sat = (m_sum > 34'h0_7FFF_FFFF) ? 32'h7FFF_FFFF : m_sum[31:0];

  // Remainder stays below m, so the 32-bit difference is exact whenever ge is set.
  assign trial_x = {rem_x, dvd_x[31]};
  assign trial_y = {rem_y, dvd_y[31]};
  assign ge_x    = trial_x >= {1'b0, m_q};
  assign ge_y    = trial_y >= {1'b0, m_q};
  assign diff_x  = trial_x[31:0] - m_q;
  assign diff_y  = trial_y[31:0] - m_q;
  assign q_x_nx  = {q_x, ge_x};
  assign q_y_nx  = {q_y, ge_y};
  assign qs_x    = (q_x_nx > 32'h0001_0000) ? 32'h0001_0000 : q_x_nx;
  assign qs_y    = (q_y_nx > 32'h0001_0000) ? 32'h0001_0000 : q_y_nx;

  assign cx = 32'(col) * 32'(CELL_SIZE) + 32'(CELL_SIZE / 2);
  assign cy = 32'(row) * 32'(CELL_SIZE) + 32'(CELL_SIZE / 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      col        <= '0;
      row        <= '0;
      au         <= '0;
      av         <= '0;
      su         <= 1'b0;
      sv         <= 1'b0;
      m_q        <= '0;
      rem_x      <= '0;
      rem_y      <= '0;
      dvd_x      <= '0;
      dvd_y      <= '0;
      q_x        <= '0;
      q_y        <= '0;
      div_cnt    <= '0;
      wait_cnt   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      vel_addr   <= '0;
      start      <= 1'b0;
      block_x    <= '0;
      block_y    <= '0;
      xn         <= '0;
      yn         <= '0;
      mag        <= '0;
    end else begin
      start      <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            col      <= '0;
            row      <= '0;
            vel_addr <= '0;
            busy     <= 1'b1;
            state    <= S_RD;
          end
        end
        S_RD: state <= S_CAP;
        S_CAP: begin
          au    <= abs_sat(vel_u);
          av    <= abs_sat(vel_v);
          su    <= vel_u[31];
          sv    <= vel_v[31];
          state <= S_MAG;
        end
        S_MAG: begin
          m_q <= m_sat;
          if (m_sat < MIN_MAG) begin
            state <= S_NEXT;
          end else begin
            // Dividend is |x|<<16; its upper 16 bits seed the remainder.
            rem_x   <= {16'h0000, au[31:16]};
            rem_y   <= {16'h0000, av[31:16]};
            dvd_x   <= {au[15:0], 16'h0000};
            dvd_y   <= {av[15:0], 16'h0000};
            q_x     <= '0;
            q_y     <= '0;
            div_cnt <= 5'd31;
            state   <= S_DIV;
          end
        end
        S_DIV: begin
          rem_x <= ge_x ? diff_x : trial_x[31:0];
          rem_y <= ge_y ? diff_y : trial_y[31:0];
          dvd_x <= {dvd_x[30:0], 1'b0};
          dvd_y <= {dvd_y[30:0], 1'b0};
          q_x   <= q_x_nx[30:0];
          q_y   <= q_y_nx[30:0];
          if (div_cnt == 5'd0) begin
            xn      <= su ? -qs_x : qs_x;
            yn      <= sv ? -qs_y : qs_y;
            mag     <= (m_q > MAX_MAG) ? MAX_MAG : m_q;
            block_x <= cx << 16;
            block_y <= cy << 16;
            start   <= 1'b1;
            state   <= S_ISSUE;
          end else begin
            div_cnt <= div_cnt - 5'd1;
          end
        end
        S_ISSUE: begin
          wait_cnt <= WCW'(DRAW_CYCLES - 1);
          state    <= S_DRAW_WAIT;
        end
        S_DRAW_WAIT: begin
          if (wait_cnt == '0) state <= S_NEXT;
          else wait_cnt <= wait_cnt - 1'b1;
        end
        S_NEXT: begin
          if (col == CW'(GRID_W - 1)) begin
            col <= '0;
            if (row == RW'(GRID_H - 1)) begin
              row        <= '0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              state      <= S_DONE;
            end else begin
              row      <= row + 1'b1;
              vel_addr <= vel_addr + 1'b1;
              state    <= S_RD;
            end
          end else begin
            col      <= col + 1'b1;
            vel_addr <= vel_addr + 1'b1;
            state    <= S_RD;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_field_sequencer.sv
// Bench for vector_field_sequencer: table vectors, directed corner sequences
// and randomized frames against an arithmetic reference model.
module tb_vector_field_sequencer;

  localparam int DRAW  = 256;
  localparam int CELLS = 48;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic        busy;
  logic        frame_done;
  logic [5:0]  vel_addr;
  logic [31:0] vel_u;
  logic [31:0] vel_v;
  logic        start;
  logic [31:0] block_x;
  logic [31:0] block_y;
  logic [31:0] xn;
  logic [31:0] yn;
  logic [31:0] mag;

  vector_field_sequencer dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .busy(busy),
    .frame_done(frame_done), .vel_addr(vel_addr), .vel_u(vel_u), .vel_v(vel_v),
    .start(start), .block_x(block_x), .block_y(block_y), .xn(xn), .yn(yn), .mag(mag)
  );

  always #5 clk = ~clk;

  logic [31:0] mem_u [CELLS];
  logic [31:0] mem_v [CELLS];

  always @(posedge clk) begin
    vel_u <= (vel_addr < 6'd48) ? mem_u[vel_addr] : 32'h0;
    vel_v <= (vel_addr < 6'd48) ? mem_v[vel_addr] : 32'h0;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [31:0] bx;
    logic [31:0] by;
    logic [31:0] xn;
    logic [31:0] yn;
    logic [31:0] mag;
  } ev_t;

  logic mon_en = 1'b0;
  int   ncyc = 0;
  int   first_busy;
  int   busy_cnt;
  int   done_busy;
  int   overlap;
  int   addr_log[$];
  int   dones[$];
  ev_t  starts[$];

  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      if (mon_en) begin
        if (busy && first_busy < 0) first_busy = ncyc;
        if (first_busy >= 0) addr_log.push_back(int'(vel_addr));
        if (busy) busy_cnt++;
        if (start) starts.push_back('{ncyc, block_x, block_y, xn, yn, mag});
        if (frame_done) begin
          dones.push_back(ncyc);
          if (busy) done_busy++;
        end
        if (start && frame_done) overlap++;
      end
    end
  end

  // Reference: alpha-max-beta-min magnitude and floor-divided unit vector.
  function automatic void model_cell(input logic [31:0] u, input logic [31:0] v,
                                     output logic drawn, output logic [31:0] exn,
                                     output logic [31:0] eyn, output logic [31:0] emag);
    longint au, av, mx, mn, m, qx, qy;
    au = u[31] ? (longint'(1) << 32) - longint'(u) : longint'(u);
    av = v[31] ? (longint'(1) << 32) - longint'(v) : longint'(v);
    if (au > 64'h7FFF_FFFF) au = 64'h7FFF_FFFF;
    if (av > 64'h7FFF_FFFF) av = 64'h7FFF_FFFF;
    mx = (au > av) ? au : av;
    mn = (au > av) ? av : au;
    m  = mx + mn / 4 + mn / 8;
    if (m > 64'h7FFF_FFFF) m = 64'h7FFF_FFFF;
    drawn = (m >= 256);
    exn = 32'h0;
    eyn = 32'h0;
    emag = 32'h0;
    if (drawn) begin
      qx = (au * 65536) / m;
      qy = (av * 65536) / m;
      if (qx > 65536) qx = 65536;
      if (qy > 65536) qy = 65536;
      exn  = u[31] ? 32'(-qx) : 32'(qx);
      eyn  = v[31] ? 32'(-qy) : 32'(qy);
      emag = (m > 64'h0014_0000) ? 32'h0014_0000 : 32'(m);
    end
  endfunction

  task automatic clear_mem();
    for (int k = 0; k < CELLS; k++) begin
      mem_u[k] = 32'h0;
      mem_v[k] = 32'h0;
    end
  endtask

  // Runs one frame and checks every address step, start pulse and the done pulse.
  task automatic run_frame(input int extra_at);
    int rd, nexp, tmo;
    logic drawn;
    logic [31:0] exn, eyn, emag;
    addr_log.delete();
    starts.delete();
    dones.delete();
    first_busy = -1;
    busy_cnt = 0;
    done_busy = 0;
    overlap = 0;
    mon_en = 1'b1;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    tmo = 0;
    while (dones.size() == 0 && tmo < 20000) begin
      @(negedge clk);
      tmo++;
      frame_start = (tmo == extra_at);
    end
    frame_start = 1'b0;
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    check("frame_done_count", dones.size(), 1);
    check("busy_after_frame", busy, 0);

    rd = 0;
    nexp = 0;
    for (int k = 0; k < CELLS; k++) begin
      check("vel_addr_step", (rd < addr_log.size()) ? addr_log[rd] : -1, k);
      model_cell(mem_u[k], mem_v[k], drawn, exn, eyn, emag);
      if (drawn) begin
        if (nexp < starts.size()) begin
          check("start_cycle", starts[nexp].cyc - first_busy, rd + 35);
          check("block_x", starts[nexp].bx, 32'((k % 8) * 40 + 20) << 16);
          check("block_y", starts[nexp].by, 32'((k / 8) * 40 + 20) << 16);
          check("xn", starts[nexp].xn, exn);
          check("yn", starts[nexp].yn, eyn);
          check("mag", starts[nexp].mag, emag);
        end
        nexp++;
        rd += 37 + DRAW;
      end else begin
        rd += 4;
      end
    end
    check("start_count", starts.size(), nexp);
    if (dones.size() > 0) check("done_cycle", dones[0] - first_busy, rd);
    check("busy_at_done", done_busy, 0);
    check("busy_cycles", busy_cnt, rd);
    check("start_done_overlap", overlap, 0);
  endtask

  function automatic logic [31:0] rnd_vel();
    logic [31:0] x;
    case ($urandom_range(0, 9))
      0: x = 32'h8000_0000;
      1: x = 32'h7FFF_FFFF;
      2, 3: x = 32'($urandom_range(0, 600));
      default: x = $urandom >> $urandom_range(0, 20);
    endcase
    if ($urandom_range(0, 1) == 1 && x != 32'h8000_0000) x = -x;
    return x;
  endfunction

  typedef struct {
    int          idx;
    logic [31:0] u;
    logic [31:0] v;
    logic [31:0] bx;
    logic [31:0] by;
    logic [31:0] xn;
    logic [31:0] yn;
    logic [31:0] mag;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{0,  32'h0000_0000, 32'h000A_0000, 32'h0014_0000, 32'h0014_0000, 32'h0000_0000, 32'h0001_0000, 32'h000A_0000};
    tbl[1] = '{47, 32'h0003_0000, 32'h0004_0000, 32'h012C_0000, 32'h00DC_0000, 32'h0000_95DA, 32'h0000_C7CE, 32'h0005_2000};
    tbl[2] = '{9,  32'hFFF6_0000, 32'h0000_0000, 32'h003C_0000, 32'h003C_0000, 32'hFFFF_0000, 32'h0000_0000, 32'h000A_0000};
    tbl[3] = '{9,  32'h0064_0000, 32'h0000_0000, 32'h003C_0000, 32'h003C_0000, 32'h0001_0000, 32'h0000_0000, 32'h0014_0000};
    tbl[4] = '{9,  32'h0000_0000, 32'hFFFF_0000, 32'h003C_0000, 32'h003C_0000, 32'h0000_0000, 32'hFFFF_0000, 32'h0001_0000};

    rst_n = 1'b0;
    frame_start = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_start", start, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_vel_addr", vel_addr, 0);
    check("rst_block_x", block_x, 0);
    check("rst_xn", xn, 0);
    check("rst_mag", mag, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      clear_mem();
      mem_u[tbl[i].idx] = tbl[i].u;
      mem_v[tbl[i].idx] = tbl[i].v;
      run_frame(0);
      check("tbl_start_seen", starts.size(), 1);
      if (starts.size() > 0) begin
        check("tbl_block_x", starts[0].bx, tbl[i].bx);
        check("tbl_block_y", starts[0].by, tbl[i].by);
        check("tbl_xn", starts[0].xn, tbl[i].xn);
        check("tbl_yn", starts[0].yn, tbl[i].yn);
        check("tbl_mag", starts[0].mag, tbl[i].mag);
        if (i == 0) begin
          check("first_start_latency", starts[0].cyc - first_busy, 35);
          check("next_addr_after_draw",
                (starts[0].cyc - first_busy + 258 < addr_log.size()) ?
                addr_log[starts[0].cyc - first_busy + 258] : -1, 1);
          check("addr_before_next",
                (starts[0].cyc - first_busy + 257 < addr_log.size()) ?
                addr_log[starts[0].cyc - first_busy + 257] : -1, 0);
        end
      end
    end

    // All-zero frame with a second frame_start while busy.
    clear_mem();
    run_frame(100);

    // Reset in the middle of a draw window, then a clean restart.
    clear_mem();
    mem_v[0] = 32'h000A_0000;
    mem_u[3] = 32'h0002_0000;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (100) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    check("pre_reset_yn", yn, 32'h0001_0000);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_start", start, 0);
    check("midrst_vel_addr", vel_addr, 0);
    check("midrst_block_x", block_x, 0);
    check("midrst_block_y", block_y, 0);
    check("midrst_yn", yn, 0);
    check("midrst_mag", mag, 0);
    check("midrst_frame_done", frame_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(0);

    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < CELLS; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          mem_u[k] = rnd_vel();
          mem_v[k] = rnd_vel();
        end else begin
          mem_u[k] = 32'h0;
          mem_v[k] = 32'h0;
        end
      end
      run_frame(0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
